// File: rtl/lab3_mem_line_memory_responder.sv
// Blocking, line-granular memory responder: accepts one 128-bit line request,
// services read/write/init against an internal array, and answers after p_latency cycles.
module lab3_mem_line_memory_responder #(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  logic [3:0]   memreq_type,
  input  logic [7:0]   memreq_opaque,
  input  logic [31:0]  memreq_addr,
  input  logic [3:0]   memreq_len,
  input  logic [127:0] memreq_data,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output logic [3:0]   memresp_type,
  output logic [7:0]   memresp_opaque,
  output logic [1:0]   memresp_test,
  output logic [3:0]   memresp_len,
  output logic [127:0] memresp_data
);

  localparam int         IW  = $clog2(p_num_lines);
  localparam logic [3:0] LAT = 4'(p_latency);

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     type_q, type_d;
  logic [7:0]     opaque_q, opaque_d;
  logic [3:0]     len_q, len_d;
  logic [127:0]   data_q, data_d;

  logic [127:0]   mem [p_num_lines];
  logic [IW-1:0]  idx;
  logic           accept;
  logic           is_read;
  logic           is_write;

  // Only the line-index bits of the address matter; the rest wrap or are ignored.
  logic unused_addr;
  assign unused_addr = &{1'b0, memreq_addr[31:4+IW], memreq_addr[3:0]};

  assign idx      = memreq_addr[4+IW-1:4];
  assign memreq_rdy = reset_n && (state_q == IDLE);
  assign accept   = memreq_val && memreq_rdy;
  assign is_read  = (memreq_type == 4'd0);
  assign is_write = (memreq_type == 4'd1) || (memreq_type == 4'd2);

  assign memresp_val    = (state_q == RESP);
  assign memresp_type   = type_q;
  assign memresp_opaque = opaque_q;
  assign memresp_len    = len_q;
  assign memresp_data   = data_q;
  assign memresp_test   = 2'd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    opaque_d = opaque_q;
    len_d    = len_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          type_d   = memreq_type;
          opaque_d = memreq_opaque;
          len_d    = memreq_len;
          // Read data is sampled from the pre-edge array contents.
          data_d   = is_read ? mem[idx] : 128'd0;
          cnt_d    = LAT;
          state_d  = (LAT != 4'd0) ? DELAY : RESP;
        end
      end
      DELAY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (memresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      type_q   <= 4'd0;
      opaque_q <= 8'd0;
      len_q    <= 4'd0;
      data_q   <= 128'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

  // Line storage is deliberately not reset; accept already requires reset_n high.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      mem[idx] <= memreq_data;
    end
  end

endmodule

// File: tb/tb_lab3_mem_line_memory_responder.sv
// Directed bench for lab3_mem_line_memory_responder: vector table plus
// hand-written latency, backpressure and reset sequences.
module tb_lab3_mem_line_memory_responder;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_val = 1'b0;
  logic [3:0]   req_type = 4'd0;
  logic [7:0]   req_opaque = 8'd0;
  logic [31:0]  req_addr = 32'd0;
  logic [3:0]   req_len = 4'd0;
  logic [127:0] req_data = 128'd0;
  logic         rsp_rdy = 1'b1;
  logic         rdy_hi = 1'b1;

  logic         memreq_rdy, memresp_val;
  logic [3:0]   memresp_type, memresp_len;
  logic [7:0]   memresp_opaque;
  logic [1:0]   memresp_test;
  logic [127:0] memresp_data;

  logic         vl0 = 1'b0, vl3 = 1'b0;
  logic         l0_rdy, l0_val, l3_rdy, l3_val;
  logic [3:0]   l0_type, l0_len, l3_type, l3_len;
  logic [7:0]   l0_op, l3_op;
  logic [1:0]   l0_test, l3_test;
  logic [127:0] l0_data, l3_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lab3_mem_line_memory_responder #(.p_num_lines(256), .p_latency(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .memreq_val(req_val), .memreq_rdy(memreq_rdy), .memreq_type(req_type),
    .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
    .memreq_data(req_data),
    .memresp_val(memresp_val), .memresp_rdy(rsp_rdy), .memresp_type(memresp_type),
    .memresp_opaque(memresp_opaque), .memresp_test(memresp_test),
    .memresp_len(memresp_len), .memresp_data(memresp_data)
  );

  lab3_mem_line_memory_responder #(.p_num_lines(256), .p_latency(0)) u_l0 (
    .clk(clk), .reset_n(reset_n),
    .memreq_val(vl0), .memreq_rdy(l0_rdy), .memreq_type(req_type),
    .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
    .memreq_data(req_data),
    .memresp_val(l0_val), .memresp_rdy(rdy_hi), .memresp_type(l0_type),
    .memresp_opaque(l0_op), .memresp_test(l0_test),
    .memresp_len(l0_len), .memresp_data(l0_data)
  );

  lab3_mem_line_memory_responder #(.p_num_lines(256), .p_latency(3)) u_l3 (
    .clk(clk), .reset_n(reset_n),
    .memreq_val(vl3), .memreq_rdy(l3_rdy), .memreq_type(req_type),
    .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
    .memreq_data(req_data),
    .memresp_val(l3_val), .memresp_rdy(rdy_hi), .memresp_type(l3_type),
    .memresp_opaque(l3_op), .memresp_test(l3_test),
    .memresp_len(l3_len), .memresp_data(l3_data)
  );

  typedef struct {
    logic [3:0]   typ;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [7:0]   op;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] DB = {4{32'hdead_beef}};
  localparam logic [127:0] D3 = 128'hcafe_f00d_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D4 = 128'h0f0f_0f0f_a5a5_a5a5_5a5a_5a5a_f0f0_f0f0;
  localparam logic [127:0] D5 = 128'h3030_3030_0303_0303_7777_8888_9999_aaaa;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request to the main DUT and check the full response and timing.
  task automatic txn(input vec_t v);
    int k;
    @(negedge clk);
    req_type = v.typ; req_addr = v.addr; req_data = v.wdata;
    req_opaque = v.op; req_len = 4'd0; req_val = 1'b1;
    k = 0;
    while (!memreq_rdy && k < 20) begin @(negedge clk); k++; end
    chk("req_rdy_wait", 128'(memreq_rdy), 128'd1);
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    k = 1;
    while (!memresp_val && k < 30) begin @(negedge clk); k++; end
    chk("resp_latency", 128'(k), 128'(LAT + 1));
    chk("resp_type", 128'(memresp_type), 128'(v.typ));
    chk("resp_opaque", 128'(memresp_opaque), 128'(v.op));
    chk("resp_len", 128'(memresp_len), 128'd0);
    chk("resp_test", 128'(memresp_test), 128'd0);
    chk("resp_data", memresp_data, v.exp);
    @(negedge clk);
    chk("post_hs_val", 128'(memresp_val), 128'd0);
    chk("post_hs_rdy", 128'(memreq_rdy), 128'd1);
  endtask

  initial begin
    vec_t v;
    int k;
    logic [127:0] held_data;
    logic [7:0]   held_op;

    vecs[0] = '{4'd2, 32'h0000_1000, D1, 8'h05, 128'd0};
    vecs[1] = '{4'd0, 32'h0000_1000, 128'd0, 8'h06, D1};
    vecs[2] = '{4'd1, 32'h0000_2010, DB, 8'h07, 128'd0};
    vecs[3] = '{4'd0, 32'h0000_201c, 128'd0, 8'h08, DB};
    vecs[4] = '{4'd1, 32'h0000_0040, D3, 8'h09, 128'd0};
    vecs[5] = '{4'd0, 32'h0000_1040, 128'd0, 8'h0a, D3};
    vecs[6] = '{4'd5, 32'h0000_1000, {128{1'b1}}, 8'h0b, 128'd0};
    vecs[7] = '{4'd0, 32'h0000_1000, 128'd0, 8'h0c, D1};
    vecs[8] = '{4'd2, 32'h0000_2010, D4, 8'h0d, 128'd0};
    vecs[9] = '{4'd0, 32'h0000_2014, 128'd0, 8'h0e, D4};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", 128'(memreq_rdy), 128'd0);
    chk("rst_resp_val", 128'(memresp_val), 128'd0);
    chk("rst_resp_fields", {memresp_type, memresp_opaque, memresp_len, memresp_test},
        128'd0);
    chk("rst_resp_data", memresp_data, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_req_rdy", 128'(memreq_rdy), 128'd1);
    chk("rel_resp_val", 128'(memresp_val), 128'd0);

    for (int i = 0; i < 10; i++) txn(vecs[i]);

    // Latency 0: response visible in the cycle right after accept
    @(negedge clk);
    req_type = 4'd2; req_addr = 32'h80; req_data = D3; req_opaque = 8'h40; vl0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vl0 = 1'b0;
    chk("l0_val_t1", 128'(l0_val), 128'd1);
    chk("l0_op", 128'(l0_op), 128'h40);
    chk("l0_rdy_in_resp", 128'(l0_rdy), 128'd0);
    @(negedge clk);
    chk("l0_val_after_hs", 128'(l0_val), 128'd0);
    chk("l0_rdy_after_hs", 128'(l0_rdy), 128'd1);

    // Latency 3: three silent cycles, response in the fourth
    req_opaque = 8'h41; vl3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vl3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("l3_val_c%0d", c), 128'(l3_val), 128'd0);
      @(negedge clk);
    end
    chk("l3_val_t4", 128'(l3_val), 128'd1);
    chk("l3_type", 128'(l3_type), 128'd2);
    @(negedge clk);
    chk("l3_val_after_hs", 128'(l3_val), 128'd0);
    chk("l3_rdy_after_hs", 128'(l3_rdy), 128'd1);

    // Backpressure: response must hold for 5 cycles, then one handshake
    rsp_rdy = 1'b0;
    req_type = 4'd0; req_addr = 32'h0000_1000; req_opaque = 8'h11; req_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    while (!memresp_val && k < 30) begin @(negedge clk); k++; end
    chk("bp_latency", 128'(k), 128'(LAT + 1));
    held_data = memresp_data;
    held_op = memresp_opaque;
    chk("bp_data", held_data, D1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", {memresp_val, memreq_rdy, memresp_type, memresp_opaque},
          {1'b1, 1'b0, 4'd0, held_op});
      chk("bp_hold_data", memresp_data, held_data);
    end
    req_val = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_after_hs", {memresp_val, memreq_rdy}, 128'b01);
    @(negedge clk);
    chk("bp_single_hs", 128'(memresp_val), 128'd0);

    // Reset during DELAY of a write: response dropped, write kept
    req_type = 4'd1; req_addr = 32'h300; req_data = D5; req_opaque = 8'h20; req_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstd_val", 128'(memresp_val), 128'd0);
    chk("rstd_rdy", 128'(memreq_rdy), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (memresp_val) k++;
    end
    chk("rstd_no_resp", 128'(k), 128'd0);
    v = '{4'd0, 32'h300, 128'd0, 8'h21, D5};
    txn(v);

    // Reset during RESP: valid and fields drop at once
    rsp_rdy = 1'b0;
    @(negedge clk);
    req_type = 4'd0; req_addr = 32'h300; req_opaque = 8'h22; req_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    k = 1;
    while (!memresp_val && k < 30) begin @(negedge clk); k++; end
    chk("rstr_val_before", 128'(memresp_val), 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstr_val_now", 128'(memresp_val), 128'd0);
    chk("rstr_fields", {memresp_opaque, memresp_data}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("rstr_rdy", 128'(memreq_rdy), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab3_mem_line_memory_responder.md
# lab3_mem_line_memory_responder

- Blocking, line-granular memory responder: the memory end of the cache-to-memory request/response stream that the base cache drives.
- Accepts one 128-bit cache-line request at a time and services refill reads, evict writes and init writes against an internal line array.
- Returns one response after a programmable latency.
- Used as the backing memory in cache unit tests and as a behavioural main memory in the composed processor-cache system.

## Interface

Parameters:
- p_num_lines, 256: number of 128-bit lines stored; power of two.
- p_latency, 2: idle cycles inserted between request accept and response valid; 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memreq_type  in  4  0 = read, 1 = write, 2 = write-init; any other value is unsupported.
- memreq_opaque  in  8  tag echoed in the response.
- memreq_addr  in  32  byte address; addr[3:0] ignored.
- memreq_len  in  4  must be 0 (full line); echoed, otherwise ignored.
- memreq_data  in  128  write line data.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.
- memresp_type  out  4  echo of the request type.
- memresp_opaque  out  8  echo of the request opaque.
- memresp_test  out  2  always 0.
- memresp_len  out  4  echo of the request len.
- memresp_data  out  128  read line data; 0 for non-read types.

## Operation

- Line index = addr[4+log2(p_num_lines)-1 : 4]. Upper address bits are ignored, so addresses wrap modulo p_num_lines*16 bytes.
- FSM states: IDLE, DELAY, RESP.
- IDLE:
  - memreq_rdy = 1, memresp_val = 0.
  - On memreq_val && memreq_rdy (the accept edge):
    - Latch type, opaque and len into the response register.
    - Read/write/init: data for a read is captured from the array before any same-edge write. Write/init commit memreq_data to the indexed line on this edge.
    - Unsupported type: array unchanged, data 0.
    - Load the counter with p_latency.
    - Go to DELAY if p_latency > 0, else go to RESP.
- DELAY:
  - memreq_rdy = 0, memresp_val = 0.
  - Counter decrements each cycle; when it reaches 1, go to RESP on that edge.
- RESP:
  - memreq_rdy = 0, memresp_val = 1.
  - All memresp_* outputs are held stable until memresp_rdy.
  - On handshake, go to IDLE.
- One request outstanding at most. A new request is never accepted in the same cycle as a response handshake.
- Write/init responses carry data 0. Read responses carry line contents as of the accept edge.
- Line array contents are not reset; they are undefined until written. Benches initialise memory with type-2 requests.

## Timing

- Request accepted at edge t → memresp_val high from cycle t+1+p_latency.
- Response handshake at edge u → memreq_rdy high in cycle u+1.
- Minimum request-to-request spacing is p_latency+2 cycles.
- memreq_rdy depends only on state, never on memreq_val. memresp_val depends only on state, never on memresp_rdy.
- Reset values while reset_n = 0 and after it deasserts:
  - state IDLE, counter 0.
  - memresp_val 0; memresp_type, memresp_opaque, memresp_len and memresp_data 0; memresp_test 0.
  - memreq_rdy forced 0 while reset_n is low, 1 from the first cycle after release.
- Reset asserted mid-DELAY or mid-RESP: the pending response is dropped. A write already committed at its accept edge remains in the array.
- memresp_rdy asserted while memresp_val = 0 has no effect. memreq_val while memreq_rdy = 0 is not consumed; the request must be held by the sender.

## Test plan

- Init then read:
  - Stimulus: init addr 0x0000_1000, data 0x0123_4567_89ab_cdef_0011_2233_4455_6677, opaque 0x05. Then read same addr, opaque 0x06.
  - Required: response type 2, data 0, opaque 0x05. Then response type 0, opaque 0x06, data equal to the init data.
- Evict-write then refill-read:
  - Stimulus: write 0x0000_2010 with data 0xdead_beef repeated four times. Read 0x0000_201c.
  - Required: the read returns the written line, because addr[3:0] is ignored.
- Latency:
  - Stimulus: p_latency = 0, then p_latency = 3, with memresp_rdy held high.
  - Required: memresp_val in cycle t+1 and t+4 respectively; the next memreq_rdy follows one cycle after each handshake.
- Backpressure:
  - Stimulus: memresp_rdy low for 5 cycles during RESP.
  - Required: memresp_val and all fields stay constant and memreq_rdy stays 0. One handshake occurs when rdy rises.
- Wrap-around:
  - Stimulus: p_num_lines = 256. Write 0x0000_0040, then read 0x0000_1040.
  - Required: the read returns the same line.
- Reset mid-operation:
  - Stimulus: pull reset_n low during DELAY of a write to 0x300, then release. Read 0x300.
  - Required: no response for the first request. memresp_val is 0 immediately on reset_n falling. The read returns the data written before the reset.
